// File: rtl/key_pkg.sv
// ============================================================================
// Module      : key_pkg
// Description : Shared constants and types for the key debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_pkg;

  localparam int unsigned CLK_HZ       = 27_000_000;
  localparam int unsigned DEB_CNT_DEF  = CLK_HZ / 50;   // 20 ms
  localparam int unsigned LONG_CNT_DEF = CLK_HZ;        // 1 s
  localparam int unsigned DEB_W        = 24;
  localparam int unsigned HOLD_W       = 25;

  typedef enum logic [0:0] {
    KS_RELEASED = 1'b0,
    KS_PRESSED  = 1'b1
  } key_st_e;

endpackage

`default_nettype wire

// File: rtl/key_debounce_if.sv
// ============================================================================
// Module      : key_debounce_if
// Description : Raw key input and debounced outputs. long_pulse exists only
//               when KEY_LONG_PRESS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface key_debounce_if;

  logic key;
  logic key_state;
  logic press_pulse;
  logic release_pulse;
`ifdef KEY_LONG_PRESS_EN
  logic long_pulse;

  modport master (output key, input key_state, input press_pulse,
                  input release_pulse, input long_pulse);
  modport slave  (input key, output key_state, output press_pulse,
                  output release_pulse, output long_pulse);
`else
  modport master (output key, input key_state, input press_pulse,
                  input release_pulse);
  modport slave  (input key, output key_state, output press_pulse,
                  output release_pulse);
`endif

endinterface

`default_nettype wire

// File: rtl/key_debounce_sync.sv
// ============================================================================
// Module      : key_sync
// Description : Two-flop synchronizer, resets to 1 (key released).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module      : key_debounce
// Description : Push-button debouncer with press/release strobes and an
//               optional long-press strobe (macro KEY_LONG_PRESS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEB_CNT  = DEB_CNT_DEF,
  parameter int unsigned LONG_CNT = LONG_CNT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  key_debounce_if.slave   bus
);

  if ((DEB_CNT < 2) || (DEB_CNT >= (1 << DEB_W))) begin : g_bad_deb_cnt
    $error("key_debounce: DEB_CNT out of range");
  end
  if ((LONG_CNT <= DEB_CNT) || (LONG_CNT >= (1 << HOLD_W))) begin : g_bad_long_cnt
    $error("key_debounce: LONG_CNT out of range");
  end

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

  logic    key_raw_sync;
  logic    key_sync;
  logic    differ;

  key_st_e          state_q,   state_d;
  logic [DEB_W-1:0] deb_q,     deb_d;
  logic             press_q,   press_d;
  logic             release_q, release_d;

  key_sync u_key_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.key),
    .q_o (key_raw_sync)
  );

  assign key_sync = ~key_raw_sync;
  assign differ   = key_sync ^ (state_q == KS_PRESSED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= KS_RELEASED;
      deb_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Counter restarts on every bounce back; toggling also clears it.
  always_comb begin
    state_d   = state_q;
    deb_d     = '0;
    if (differ) begin
      if (deb_q == DEB_LAST) begin
        state_d = (state_q == KS_PRESSED) ? KS_RELEASED : KS_PRESSED;
      end else begin
        deb_d = deb_q + DEB_W'(1);
      end
    end
    press_d   = (state_q == KS_RELEASED) && (state_d == KS_PRESSED);
    release_d = (state_q == KS_PRESSED)  && (state_d == KS_RELEASED);
  end

  always_comb begin
    bus.key_state     = (state_q == KS_PRESSED);
    bus.press_pulse   = press_q;
    bus.release_pulse = release_q;
  end

`ifdef KEY_LONG_PRESS_EN
  localparam logic [HOLD_W-1:0] LONG_MAX = HOLD_W'(LONG_CNT);
  localparam logic [HOLD_W-1:0] LONG_PRE = HOLD_W'(LONG_CNT - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  // Suppressed when the release lands on the same edge, so it never
  // coincides with release_pulse.
  always_comb begin
    hold_d = '0;
    long_d = 1'b0;
    if (state_q == KS_PRESSED) begin
      hold_d = (hold_q < LONG_MAX) ? hold_q + HOLD_W'(1) : hold_q;
      long_d = (hold_q == LONG_PRE) && (state_d == KS_PRESSED);
    end
  end

  assign bus.long_pulse = long_q;
`endif

endmodule

`default_nettype wire

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEB_CNT, default 540000, debounce window in clk cycles (20 ms at 27 MHz); legal range 2 to 2^24-1.
REQ-002 SHALL have parameter LONG_CNT, default 27000000, long-press threshold in clk cycles (1 s at 27 MHz); legal range DEB_CNT+1 to 2^25-1.
REQ-003 SHALL have port clk, input, 1, system clock (27 MHz); one clock, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port key, input, 1, raw asynchronous push-button, active-low (0 = pressed).
REQ-006 SHALL have port key_state, output, 1, debounced level, 1 = pressed.
REQ-007 SHALL have port press_pulse, output, 1, single-cycle strobe on debounced press.
REQ-008 SHALL have port release_pulse, output, 1, single-cycle strobe on debounced release.
REQ-009 SHALL have port long_pulse, output, 1, single-cycle strobe when press held LONG_CNT cycles (present only with the macro in REQ-024).

Function
REQ-010 SHALL pass key through a 2-flop synchronizer before any other use; key_sync is the inverted second-flop output (1 = pressed).
REQ-011 SHALL keep a debounce counter, width 24 bits: cleared when key_sync equals key_state, else incremented each cycle.
REQ-012 SHALL toggle key_state on the cycle after the counter reaches DEB_CNT-1 with key_sync still differing, and clear the counter on that same cycle.
REQ-013 SHALL ignore any key_sync excursion shorter than DEB_CNT consecutive cycles: counter restarts at 0 on every bounce back; key_state and all pulses unchanged.
REQ-014 SHALL assert press_pulse for exactly one cycle, coincident with key_state 0->1; release_pulse likewise on 1->0; never both in the same cycle.
REQ-015 SHALL give latency from a clean key edge to key_state/press_pulse of exactly DEB_CNT+2 cycles (2 synchronizer + DEB_CNT debounce).
REQ-016 SHALL keep a 25-bit hold counter: cleared while key_state=0, incremented while key_state=1, saturating at LONG_CNT.
REQ-017 SHALL assert long_pulse for one cycle when the hold counter transitions LONG_CNT-1 -> LONG_CNT; no repeat while held; re-armed only after release.
REQ-018 SHALL still issue release_pulse on release after a long press; long_pulse and release_pulse never coincide.
REQ-019 SHALL register all outputs (no combinational path from key to any output).

Reset
REQ-020 SHALL, with rst=1 at a clk edge, set synchronizer flops to 1 (idle, released), counters to 0, key_state/press_pulse/release_pulse/long_pulse to 0.
REQ-021 SHALL abort any in-progress debounce or hold count on reset mid-operation, emitting no pulse during or on exit from reset.
REQ-022 SHALL, if key is held pressed through reset deassertion, treat it as a new press: press_pulse DEB_CNT+2 cycles after rst falls (within one cycle, synchronizer refill).
REQ-023 SHALL not require reset for synchronizer correctness beyond the first two cycles.

Configuration
REQ-024 SHALL support macro KEY_LONG_PRESS_EN: defined -> hold counter and long_pulse per REQ-016..018; undefined -> hold counter absent, long_pulse port absent, all other behaviour identical.

Structure
REQ-025 SHALL place DEB_CNT/LONG_CNT defaults, counter widths (24, 25) and the 27 MHz clock constant in the shared package key_pkg.
REQ-026 SHALL implement the 2-flop synchronizer as sub-module key_sync (reset value 1), instantiated once.
REQ-027 SHALL drive downstream key_ctl from press_pulse (and long_pulse when enabled), not from raw key.

Verification (bench uses DEB_CNT=8, LONG_CNT=40, macro defined unless stated)
REQ-028 SHALL test clean press at cycle 100: press_pulse and key_state=1 at cycle 110 exactly; release at 200 -> release_pulse at 210.
REQ-029 SHALL test bounce: key toggled low 3 cycles/high 2 cycles x5, then stable low -> one press_pulse only, 10 cycles after last bounce edge.
REQ-030 SHALL test glitch: key low for 7 cycles then high -> no pulse, key_state stays 0.
REQ-031 SHALL test long press held 100 cycles -> one press_pulse, one long_pulse 40 cycles later, one release_pulse on release, none coincident.
REQ-032 SHALL test rst=1 for 3 cycles mid-debounce (counter=5) and mid-hold (counter=30) -> all outputs 0, no pulses; key still low -> press_pulse 10 cycles after rst falls.
REQ-033 SHALL rerun REQ-028 and REQ-031 with KEY_LONG_PRESS_EN undefined -> identical press/release timing, no long_pulse port.
